estacao_reserva_add: RTL and testbench
======================================

Name: estacao_reserva_add

Overview:
- One ADD/SUB reservation station of the Tomasulo core.
- Receives an issued operation from the dispatch unit (Enable_VQ/Vj/Vk/Qj/Qk/Ufop/R_target) and resolves pending operands by snooping the common data bus (CDB).
- Executes once both operands are valid, then requests the CDB and broadcasts its result tagged with its own station ID.
- Busy is the handshake back to dispatch; two instances (tags 1 and 2) form ADD1/ADD2.

Parameters:
- STATION_TAG, 3'd1, this station's tag on the CDB and in the register status table (ADD2 instance uses 3'd2).
- EXEC_LATENCY, 2, cycles spent in EXEC; legal range 1..15.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Enable_VQ  in  1  dispatch strobe: capture the operands on this edge.
- Ufop  in  3  operation code.
- Vj, Vk  in  16  operand values; meaningful only when the matching Q is 0.
- Qj, Qk  in  3  producing station tag; 0 means the value is ready.
- R_target  in  4  destination register, carried through to writeback.
- CDB_valid  in  1  a broadcast is present on the CDB this cycle.
- CDB_tag  in  3  tag of the broadcasting station.
- CDB_data  in  16  broadcast value.
- CDB_grant  in  1  arbiter grant for this station's request.
- Busy  out  1  station is occupied.
- CDB_req  out  1  result ready; requesting the CDB.
- Out_tag  out  3  equals STATION_TAG while CDB_req is high, else 0.
- Out_data  out  16  result value.
- Out_R_target  out  4  destination register of the result.
- Issue_drop  out  1  one-cycle pulse: an Enable_VQ arrived while Busy and was discarded.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State IDLE; Busy=0, CDB_req=0, Issue_drop=0.
  - Out_tag=0, Out_data=16'hFFF0, Out_R_target=0.
  - Internal Vj/Vk=16'hFFF0, Qj/Qk=0, counter=0.
  - A reset asserted mid-operation discards the operation; no broadcast occurs.
- IDLE, Enable_VQ=1:
  - Latch Ufop, R_target, Vj/Qj, Vk/Qk; Busy=1 from the next cycle.
  - Same-edge forward: if CDB_valid and CDB_tag==Qj (Qj≠0), latch CDB_data as Vj and clear Qj. Vk/Qk are handled the same way.
  - Next state: EXEC if both Q end up 0, else WAIT_OPS.
- WAIT_OPS:
  - Each cycle, a nonzero Qj matching CDB_tag with CDB_valid=1 captures CDB_data into Vj and clears Qj. Same for Qk; both may resolve on the same edge.
  - Moves to EXEC on the edge where the last Q clears.
  - Tag 0 on the CDB is never matched.
- EXEC:
  - Counter loads EXEC_LATENCY-1 on entry and decrements each cycle; at 0, latch the result into Out_data and Out_R_target and go to WB.
  - Ufop 3'b001: Vj+Vk. Ufop 3'b010: Vj−Vk. Any other Ufop: result is Vj.
  - Arithmetic is 16-bit modulo 2^16; the carry is discarded.
- WB:
  - CDB_req=1 and Out_tag=STATION_TAG, held stable until CDB_grant=1 is sampled.
  - On the grant edge: CDB_req=0, Out_tag=0, Busy=0, state IDLE. The broadcast is the single cycle in which req and grant are both high.
  - Without a grant, the station waits indefinitely.
- Busy rule: Busy=1 in WAIT_OPS, EXEC and WB. Enable_VQ while Busy=1 is ignored, state is unchanged, and Issue_drop pulses for one cycle.
- Back-to-back issue: Enable_VQ on the cycle immediately after the grant edge is accepted.
- Own-tag dependency: Qj/Qk==STATION_TAG is legal only when it refers to an earlier broadcast already on the CDB; it is matched like any other tag.
- Minimum latency, issue to CDB_req with both operands ready: 1 (capture) + EXEC_LATENCY cycles.

Decomposition:
- Shared package (tomasulo_pkg):
  - UFOP_ADD=3'b001, UFOP_SUB=3'b010.
  - TAG_NONE=3'd0, TAG_ADD1=3'd1, TAG_ADD2=3'd2.
  - VAL_SEM_VALOR=16'hFFF0.
  - State enum IDLE/WAIT_OPS/EXEC/WB.
- One sub-module, operand_slot: holds V/Q for a single operand, capture-from-dispatch plus CDB-snoop logic; instantiated twice (j, k).

Test Plan:
- Ready issue: Vj=5, Vk=3, Qj=Qk=0, Ufop=001, R_target=4 → CDB_req after 1+2 cycles with Out_data=8, Out_tag=1, Out_R_target=4; grant → Busy=0 the next cycle.
- Pending operand: Qj=2, Vk=10, Ufop=010; three cycles later CDB_valid, tag=2, data=25 → EXEC entered on that edge, Out_data=15.
- Same-edge forward: Enable_VQ with Qk=2 while the CDB broadcasts tag 2, data=7 → no WAIT_OPS; Vk=7 is used.
- Simultaneous resolve: Qj=Qk=2, a single broadcast with data=9 → both captured, Ufop=001 gives Out_data=18.
- Busy issue plus grant stall: Enable_VQ while in EXEC → Issue_drop pulses and the operands are unchanged; grant withheld 5 cycles → CDB_req and Out_* stable throughout.
- Reset mid-WAIT_OPS: drive Reset=0 → outputs take reset values immediately; a later broadcast of the awaited tag causes no capture.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core: opcodes, station tags, the
// "no value" marker and the reservation station state encoding.
package tomasulo_pkg;

  localparam logic [2:0]  UFOP_ADD      = 3'b001;
  localparam logic [2:0]  UFOP_SUB      = 3'b010;

  localparam logic [2:0]  TAG_NONE      = 3'd0;
  localparam logic [2:0]  TAG_ADD1      = 3'd1;
  localparam logic [2:0]  TAG_ADD2      = 3'd2;

  localparam logic [15:0] VAL_SEM_VALOR = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPS,
    EXEC,
    WB
  } rs_state_e;

  // Unknown opcodes pass Vj through unchanged.
  function automatic logic [15:0] alu_result(input logic [2:0]  op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
    logic [15:0] r;
    case (op)
      UFOP_ADD: r = a + b;
      UFOP_SUB: r = a - b;
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/estacao_reserva_add_operand_slot.sv
// One operand of a reservation station: value/tag pair captured from dispatch
// and resolved by snooping the common data bus.
module operand_slot
  import tomasulo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        snoop,
  input  logic [15:0] v_in,
  input  logic [2:0]  q_in,
  input  logic        cdb_valid,
  input  logic [2:0]  cdb_tag,
  input  logic [15:0] cdb_data,
  output logic [15:0] v_q,
  output logic [2:0]  q_q,
  output logic [2:0]  q_d
);

  logic [15:0] v_d;

  always_comb begin
    v_d = v_q;
    q_d = q_q;
    if (load) begin
      // A broadcast on the issue edge forwards straight into the slot.
      if (cdb_valid && (q_in != TAG_NONE) && (cdb_tag == q_in)) begin
        v_d = cdb_data;
        q_d = TAG_NONE;
      end else begin
        v_d = v_in;
        q_d = q_in;
      end
    end else if (snoop && cdb_valid && (q_q != TAG_NONE) && (cdb_tag == q_q)) begin
      v_d = cdb_data;
      q_d = TAG_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= VAL_SEM_VALOR;
      q_q <= TAG_NONE;
    end else begin
      v_q <= v_d;
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/estacao_reserva_add.sv
// ADD/SUB reservation station: waits for operands on the CDB, executes for
// EXEC_LATENCY cycles, then holds its result on the CDB request until granted.
module estacao_reserva_add
  import tomasulo_pkg::*;
#(
  parameter logic [2:0] STATION_TAG  = 3'd1,
  parameter int         EXEC_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable_VQ,
  input  logic [2:0]  Ufop,
  input  logic [15:0] Vj,
  input  logic [15:0] Vk,
  input  logic [2:0]  Qj,
  input  logic [2:0]  Qk,
  input  logic [3:0]  R_target,
  input  logic        CDB_valid,
  input  logic [2:0]  CDB_tag,
  input  logic [15:0] CDB_data,
  input  logic        CDB_grant,
  output logic        Busy,
  output logic        CDB_req,
  output logic [2:0]  Out_tag,
  output logic [15:0] Out_data,
  output logic [3:0]  Out_R_target,
  output logic        Issue_drop
);

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_LATENCY - 1);

  rs_state_e   state_q, state_d;
  logic [3:0]  counter_q, counter_d;
  logic [2:0]  ufop_q, ufop_d;
  logic [3:0]  r_target_q, r_target_d;
  logic [15:0] out_data_q, out_data_d;
  logic [3:0]  out_r_target_q, out_r_target_d;
  logic        issue_drop_q, issue_drop_d;

  logic        load, snoop;
  logic [15:0] vj_q, vk_q;
  logic [2:0]  qj_q, qk_q, qj_d, qk_d;

  operand_slot u_slot_j (
    .clk(Clock), .rst_n(Reset), .load(load), .snoop(snoop),
    .v_in(Vj), .q_in(Qj),
    .cdb_valid(CDB_valid), .cdb_tag(CDB_tag), .cdb_data(CDB_data),
    .v_q(vj_q), .q_q(qj_q), .q_d(qj_d)
  );

  operand_slot u_slot_k (
    .clk(Clock), .rst_n(Reset), .load(load), .snoop(snoop),
    .v_in(Vk), .q_in(Qk),
    .cdb_valid(CDB_valid), .cdb_tag(CDB_tag), .cdb_data(CDB_data),
    .v_q(vk_q), .q_q(qk_q), .q_d(qk_d)
  );

  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    ufop_d         = ufop_q;
    r_target_d     = r_target_q;
    out_data_d     = out_data_q;
    out_r_target_d = out_r_target_q;
    issue_drop_d   = Enable_VQ && (state_q != IDLE);
    load           = 1'b0;
    snoop          = (state_q == WAIT_OPS);

    case (state_q)
      IDLE: begin
        if (Enable_VQ) begin
          load       = 1'b1;
          ufop_d     = Ufop;
          r_target_d = R_target;
          counter_d  = CNT_LOAD;
          state_d    = ((qj_d == TAG_NONE) && (qk_d == TAG_NONE)) ? EXEC : WAIT_OPS;
        end
      end
      WAIT_OPS: begin
        if ((qj_d == TAG_NONE) && (qk_d == TAG_NONE)) begin
          counter_d = CNT_LOAD;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (counter_q == 4'd0) begin
          out_data_d     = alu_result(ufop_q, vj_q, vk_q);
          out_r_target_d = r_target_q;
          state_d        = WB;
        end else begin
          counter_d = counter_q - 4'd1;
        end
      end
      WB: begin
        if (CDB_grant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q        <= IDLE;
      counter_q      <= 4'd0;
      ufop_q         <= 3'd0;
      r_target_q     <= 4'd0;
      out_data_q     <= VAL_SEM_VALOR;
      out_r_target_q <= 4'd0;
      issue_drop_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      ufop_q         <= ufop_d;
      r_target_q     <= r_target_d;
      out_data_q     <= out_data_d;
      out_r_target_q <= out_r_target_d;
      issue_drop_q   <= issue_drop_d;
    end
  end

  assign Busy         = (state_q != IDLE);
  assign CDB_req      = (state_q == WB);
  assign Out_tag      = (state_q == WB) ? STATION_TAG : TAG_NONE;
  assign Out_data     = out_data_q;
  assign Out_R_target = out_r_target_q;
  assign Issue_drop   = issue_drop_q;

endmodule

// File: tb/tb_estacao_reserva_add.sv
// Directed bench for estacao_reserva_add (tag 1, latency 2).
module tb_estacao_reserva_add;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Enable_VQ;
  logic [2:0]  Ufop;
  logic [15:0] Vj, Vk;
  logic [2:0]  Qj, Qk;
  logic [3:0]  R_target;
  logic        CDB_valid;
  logic [2:0]  CDB_tag;
  logic [15:0] CDB_data;
  logic        CDB_grant;
  logic        Busy, CDB_req, Issue_drop;
  logic [2:0]  Out_tag;
  logic [15:0] Out_data;
  logic [3:0]  Out_R_target;

  int pass_cnt = 0;
  int total_cnt = 0;

  estacao_reserva_add #(.STATION_TAG(3'd1), .EXEC_LATENCY(2)) dut (
    .Clock(Clock), .Reset(Reset), .Enable_VQ(Enable_VQ), .Ufop(Ufop),
    .Vj(Vj), .Vk(Vk), .Qj(Qj), .Qk(Qk), .R_target(R_target),
    .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
    .CDB_grant(CDB_grant), .Busy(Busy), .CDB_req(CDB_req),
    .Out_tag(Out_tag), .Out_data(Out_data), .Out_R_target(Out_R_target),
    .Issue_drop(Issue_drop)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %-22s observed=%0h expected=%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] vj_i, input logic [2:0] qj_i,
                       input logic [15:0] vk_i, input logic [2:0] qk_i, input logic [3:0] rt);
    Enable_VQ = 1'b1; Ufop = op; Vj = vj_i; Qj = qj_i; Vk = vk_i; Qk = qk_i; R_target = rt;
  endtask

  task automatic cdb(input logic v, input logic [2:0] t, input logic [15:0] d);
    CDB_valid = v; CDB_tag = t; CDB_data = d;
  endtask

  task automatic check_result(input string tag, input logic [15:0] data, input logic [3:0] rt);
    check({tag, "_req"}, 32'(CDB_req), 32'd1);
    check({tag, "_tag"}, 32'(Out_tag), 32'd1);
    check({tag, "_data"}, 32'(Out_data), 32'(data));
    check({tag, "_rt"}, 32'(Out_R_target), 32'(rt));
  endtask

  initial begin
    Reset = 1'b0; Enable_VQ = 1'b0; Ufop = 3'd0; Vj = 16'd0; Vk = 16'd0;
    Qj = 3'd0; Qk = 3'd0; R_target = 4'd0; CDB_grant = 1'b0;
    cdb(1'b0, 3'd0, 16'd0);
    #12;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_req", 32'(CDB_req), 32'd0);
    check("rst_tag", 32'(Out_tag), 32'd0);
    check("rst_data", 32'(Out_data), 32'hFFF0);
    check("rst_rt", 32'(Out_R_target), 32'd0);
    check("rst_drop", 32'(Issue_drop), 32'd0);
    Reset = 1'b1;
    step();

    // Ready issue: 5 + 3 -> 8, request after capture + 2 cycles.
    issue(3'b001, 16'd5, 3'd0, 16'd3, 3'd0, 4'd4);
    step(); Enable_VQ = 1'b0;
    check("t1_busy", 32'(Busy), 32'd1);
    check("t1_req_e0", 32'(CDB_req), 32'd0);
    step();
    check("t1_req_e1", 32'(CDB_req), 32'd0);
    step();
    check_result("t1", 16'd8, 4'd4);
    CDB_grant = 1'b1;
    step(); CDB_grant = 1'b0;
    check("t1_busy_after", 32'(Busy), 32'd0);
    check("t1_req_after", 32'(CDB_req), 32'd0);
    check("t1_tag_after", 32'(Out_tag), 32'd0);

    // Pending Qj=2, tag-0 broadcast ignored, resolved by tag 2 data 25: 25-10=15.
    issue(3'b010, 16'd0, 3'd2, 16'd10, 3'd0, 4'd5);
    step(); Enable_VQ = 1'b0;
    cdb(1'b1, 3'd0, 16'd99);
    step(); cdb(1'b0, 3'd0, 16'd0);
    step();
    check("t2_busy_wait", 32'(Busy), 32'd1);
    cdb(1'b1, 3'd2, 16'd25);
    step(); cdb(1'b0, 3'd0, 16'd0);
    step();
    check("t2_req_early", 32'(CDB_req), 32'd0);
    step();
    check_result("t2", 16'd15, 4'd5);
    CDB_grant = 1'b1;
    step(); CDB_grant = 1'b0;

    // Same-edge forward of Vk=7: 100+7, no WAIT_OPS.
    issue(3'b001, 16'd100, 3'd0, 16'd0, 3'd2, 4'd6);
    cdb(1'b1, 3'd2, 16'd7);
    step(); Enable_VQ = 1'b0; cdb(1'b0, 3'd0, 16'd0);
    step(); step();
    check_result("t3", 16'd107, 4'd6);
    CDB_grant = 1'b1;
    step(); CDB_grant = 1'b0;

    // Back-to-back issue; both operands wait on tag 2, one broadcast of 9 -> 18.
    issue(3'b001, 16'd0, 3'd2, 16'd0, 3'd2, 4'd8);
    step(); Enable_VQ = 1'b0;
    check("t4_b2b_busy", 32'(Busy), 32'd1);
    cdb(1'b1, 3'd2, 16'd9);
    step(); cdb(1'b0, 3'd0, 16'd0);
    step(); step();
    check_result("t4", 16'd18, 4'd8);
    CDB_grant = 1'b1;
    step(); CDB_grant = 1'b0;

    // Busy issue during EXEC is dropped; 8000+9000 wraps to 1000; grant stalled.
    issue(3'b001, 16'h8000, 3'd0, 16'h9000, 3'd0, 4'd7);
    step();
    issue(3'b010, 16'd1, 3'd0, 16'd1, 3'd0, 4'd3);
    step(); Enable_VQ = 1'b0;
    check("t5_drop_pulse", 32'(Issue_drop), 32'd1);
    step();
    check("t5_drop_clear", 32'(Issue_drop), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check_result($sformatf("t5_stall%0d", i), 16'h1000, 4'd7);
      step();
    end
    CDB_grant = 1'b1;
    step(); CDB_grant = 1'b0;
    check("t5_req_after", 32'(CDB_req), 32'd0);

    // Unknown opcode passes Vj through.
    issue(3'b111, 16'h1234, 3'd0, 16'd5, 3'd0, 4'd9);
    step(); Enable_VQ = 1'b0;
    step(); step();
    check_result("t6", 16'h1234, 4'd9);
    CDB_grant = 1'b1;
    step(); CDB_grant = 1'b0;

    // Asynchronous reset while waiting on own tag; later broadcast must not revive it.
    issue(3'b001, 16'd0, 3'd1, 16'd3, 3'd0, 4'd2);
    step(); Enable_VQ = 1'b0;
    step();
    check("t7_busy_pre", 32'(Busy), 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("t7_rst_busy", 32'(Busy), 32'd0);
    check("t7_rst_data", 32'(Out_data), 32'hFFF0);
    check("t7_rst_rt", 32'(Out_R_target), 32'd0);
    check("t7_rst_tag", 32'(Out_tag), 32'd0);
    #3 Reset = 1'b1;
    step();
    cdb(1'b1, 3'd1, 16'd50);
    step(); cdb(1'b0, 3'd0, 16'd0);
    step(); step(); step();
    check("t7_post_busy", 32'(Busy), 32'd0);
    check("t7_post_req", 32'(CDB_req), 32'd0);
    check("t7_post_data", 32'(Out_data), 32'hFFF0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
